// File: rtl/upsp_col_fetch.sv
// Source-window fetch for up-sampling: buffers 4 source lines and emits one
// vertical 4-tap column (rows y-1..y+2, edge-replicated) per source pixel.
module upsp_col_fetch #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SRC_IMG_WIDTH  = 1920,
  parameter int unsigned SRC_IMG_HEIGHT = 1080
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                ac_upsp_rvalid,
  input  logic [DATA_WIDTH-1:0]               ac_upsp_rdata,
  output logic                                upsp_ac_rready,
  output logic                                col_valid,
  input  logic                                col_ready,
  output logic [4*DATA_WIDTH-1:0]             col_data,
  output logic [$clog2(SRC_IMG_WIDTH)-1:0]    col_x,
  output logic [$clog2(SRC_IMG_HEIGHT)-1:0]   col_y,
  output logic                                col_eol,
  output logic                                col_eof
);

  localparam int unsigned DW     = DATA_WIDTH;
  localparam int unsigned W      = SRC_IMG_WIDTH;
  localparam int unsigned H      = SRC_IMG_HEIGHT;
  localparam int unsigned XW     = $clog2(W);
  localparam int unsigned YW     = $clog2(H);
  localparam int unsigned YCW    = $clog2(H + 1);
  localparam int unsigned YEW    = YCW + 2;
  localparam int unsigned NBANKS = 4;
  localparam int unsigned NTAPS  = 4;

  logic [XW-1:0]  in_x, in_x_n, rd_x, rd_x_n;
  logic [YCW-1:0] in_y, in_y_n, rd_y, rd_y_n;
  logic [YCW-1:0] need;
  logic           in_hs, out_hs, fetch_ok, re, rready_n, col_valid_n;
  logic [1:0]     sel_n [NTAPS];
  logic [1:0]     sel_q [NTAPS];
  logic [DW-1:0]  mem    [NBANKS][W];
  logic [DW-1:0]  bank_q [NBANKS];

  function automatic logic [YCW-1:0] clamp_hi(input logic [YEW-1:0] r);
    return (r > YEW'(H - 1)) ? YCW'(H - 1) : YCW'(r);
  endfunction

  // Input may overwrite a bank slot only once column (ix, iy-3) has been fetched.
  function automatic logic in_gate(input logic [XW-1:0] ix, input logic [YCW-1:0] iy,
                                   input logic [XW-1:0] rx, input logic [YCW-1:0] ry);
    logic [YEW-1:0] iy_e;
    logic [YEW-1:0] ry3;
    iy_e = YEW'(iy);
    ry3  = YEW'(ry) + YEW'(3);
    return (iy_e < YEW'(H)) &&
           ((iy_e < YEW'(3)) || (ry3 > iy_e) || ((ry3 == iy_e) && (rx > ix)));
  endfunction

  // Fetch decision and per-tap bank selects.
  always_comb begin
    in_hs    = ac_upsp_rvalid & upsp_ac_rready;
    out_hs   = col_valid & col_ready;
    need     = clamp_hi(YEW'(rd_y) + YEW'(2));
    fetch_ok = (in_y > need) || ((in_y == need) && (in_x > rd_x));
    re       = fetch_ok && (rd_y < YCW'(H)) && (!col_valid || col_ready);
    sel_n[0] = (rd_y == '0) ? 2'd0 : 2'(rd_y - YCW'(1));
    sel_n[1] = 2'(rd_y);
    sel_n[2] = 2'(clamp_hi(YEW'(rd_y) + YEW'(1)));
    sel_n[3] = 2'(need);
  end

  // Next-state of the input/read counters and the registered handshakes.
  always_comb begin
    in_x_n      = in_x;
    in_y_n      = in_y;
    rd_x_n      = rd_x;
    rd_y_n      = rd_y;
    col_valid_n = re | (col_valid & ~col_ready);
    if (out_hs && col_eof) begin
      in_x_n = '0;
      in_y_n = '0;
      rd_x_n = '0;
      rd_y_n = '0;
    end else begin
      if (in_hs) begin
        if (in_x == XW'(W - 1)) begin
          in_x_n = '0;
          in_y_n = in_y + YCW'(1);
        end else begin
          in_x_n = in_x + XW'(1);
        end
      end
      if (re) begin
        if (rd_x == XW'(W - 1)) begin
          rd_x_n = '0;
          rd_y_n = rd_y + YCW'(1);
        end else begin
          rd_x_n = rd_x + XW'(1);
        end
      end
    end
    rready_n = in_gate(in_x_n, in_y_n, rd_x_n, rd_y_n);
  end

  // Line banks: source row n lives in bank n%4.
  always_ff @(posedge clk) begin
    if (in_hs) mem[in_y[1:0]][in_x] <= ac_upsp_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_x           <= '0;
      in_y           <= '0;
      rd_x           <= '0;
      rd_y           <= '0;
      upsp_ac_rready <= 1'b1;
      col_valid      <= 1'b0;
      col_x          <= '0;
      col_y          <= '0;
      col_eol        <= 1'b0;
      col_eof        <= 1'b0;
      for (int b = 0; b < NBANKS; b++) bank_q[b] <= '0;
      for (int k = 0; k < NTAPS; k++)  sel_q[k]  <= 2'd0;
    end else begin
      in_x           <= in_x_n;
      in_y           <= in_y_n;
      rd_x           <= rd_x_n;
      rd_y           <= rd_y_n;
      upsp_ac_rready <= rready_n;
      col_valid      <= col_valid_n;
      if (re) begin
        col_x   <= rd_x;
        col_y   <= YW'(rd_y);
        col_eol <= (rd_x == XW'(W - 1));
        col_eof <= (rd_x == XW'(W - 1)) && (rd_y == YCW'(H - 1));
        for (int b = 0; b < NBANKS; b++) bank_q[b] <= mem[b][rd_x];
        for (int k = 0; k < NTAPS; k++)  sel_q[k]  <= sel_n[k];
      end
    end
  end

  // Bank outputs only change on a fetch, so the taps hold under backpressure.
  always_comb begin
    col_data = '0;
    for (int k = 0; k < NTAPS; k++) col_data[k*DW +: DW] = bank_q[sel_q[k]];
  end

endmodule

// File: tb/tb_upsp_col_fetch.sv
// Scoreboard bench for upsp_col_fetch: a 4x4 instance for tap-order, latency and
// backpressure checks, an 8x6 instance for random stalls and mid-frame reset.
module tb_upsp_col_fetch;

  localparam int AW = 4, AH = 4, BW = 8, BH = 6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rvalid;
  logic [31:0]  rdata;
  logic         col_ready;
  logic         use_b;

  logic         a_rready, a_valid, a_eol, a_eof;
  logic [127:0] a_data;
  logic [1:0]   a_x, a_y;
  logic         b_rready, b_valid, b_eol, b_eof;
  logic [127:0] b_data;
  logic [2:0]   b_x, b_y;

  logic         m_rready, m_valid, m_eol, m_eof;
  logic [127:0] m_data;
  logic [3:0]   m_x, m_y;

  always #5 clk = ~clk;

  upsp_col_fetch #(.DATA_WIDTH(32), .SRC_IMG_WIDTH(AW), .SRC_IMG_HEIGHT(AH)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .ac_upsp_rvalid(rvalid & ~use_b), .ac_upsp_rdata(rdata), .upsp_ac_rready(a_rready),
    .col_valid(a_valid), .col_ready(col_ready & ~use_b), .col_data(a_data),
    .col_x(a_x), .col_y(a_y), .col_eol(a_eol), .col_eof(a_eof));

  upsp_col_fetch #(.DATA_WIDTH(32), .SRC_IMG_WIDTH(BW), .SRC_IMG_HEIGHT(BH)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .ac_upsp_rvalid(rvalid & use_b), .ac_upsp_rdata(rdata), .upsp_ac_rready(b_rready),
    .col_valid(b_valid), .col_ready(col_ready & use_b), .col_data(b_data),
    .col_x(b_x), .col_y(b_y), .col_eol(b_eol), .col_eof(b_eof));

  assign m_rready = use_b ? b_rready : a_rready;
  assign m_valid  = use_b ? b_valid  : a_valid;
  assign m_data   = use_b ? b_data   : a_data;
  assign m_x      = use_b ? 4'(b_x)  : 4'(a_x);
  assign m_y      = use_b ? 4'(b_y)  : 4'(a_y);
  assign m_eol    = use_b ? b_eol    : a_eol;
  assign m_eof    = use_b ? b_eof    : a_eof;

  typedef struct {
    int           x;
    int           y;
    logic [127:0] data;
    bit           eol;
    bit           eof;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [31:0] frame [8][8];
  int          checks = 0, failures = 0;
  int          cyc = 0;
  int          cur_w, cur_h;
  int          ready_mode;
  int          acc_cnt, first_block;
  int          t_hs, t_valid;
  bit          lat_arm, basic_chk, prev_valid, eof_pend;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic int clampr(input int r);
    if (r < 0) return 0;
    if (r > cur_h - 1) return cur_h - 1;
    return r;
  endfunction

  // Reference model: build a frame and queue every column it must produce.
  task automatic load_frame(input bit rnd);
    exp_t t;
    for (int y = 0; y < cur_h; y++)
      for (int x = 0; x < cur_w; x++)
        frame[y][x] = rnd ? $urandom : 32'(16 * y + x);
    for (int y = 0; y < cur_h; y++)
      for (int x = 0; x < cur_w; x++) begin
        t.x    = x;
        t.y    = y;
        t.data = {frame[clampr(y + 2)][x], frame[clampr(y + 1)][x],
                  frame[y][x], frame[clampr(y - 1)][x]};
        t.eol  = (x == cur_w - 1);
        t.eof  = (x == cur_w - 1) && (y == cur_h - 1);
        q.push_back(t);
      end
  endtask

  task automatic drive_frame(input int pct, input int npix);
    for (int idx = 0; idx < npix; idx++) begin
      int  waited = 0;
      bit  hs = 0;
      while (!hs) begin
        @(posedge clk);
        #1;
        rvalid = ($urandom_range(99) < pct);
        rdata  = frame[idx / cur_w][idx % cur_w];
        @(negedge clk);
        if (rvalid && m_rready) hs = 1;
        else begin
          if (rvalid && first_block < 0) first_block = acc_cnt;
          waited++;
          if (waited > 2000) begin
            check("pixel_accept_timeout", 128'(idx), 128'(-1));
            rvalid = 1'b0;
            return;
          end
        end
      end
      acc_cnt++;
      if (idx == 2 * cur_w) t_hs = cyc;
    end
    @(posedge clk);
    #1;
    rvalid = 1'b0;
  endtask

  task automatic wait_empty(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("queue_drained", 128'(q.size()), 128'(0));
  endtask

  initial begin
    col_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       col_ready = 1'b0;
        1:       col_ready = 1'b1;
        default: col_ready = 1'($urandom_range(1));
      endcase
    end
  end

  // Monitor: every valid cycle must show the head of the queue; pop on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      eof_pend   = 1'b0;
    end else begin
      if (eof_pend) begin
        check("rready_after_eof", 128'(m_rready), 128'(1));
        eof_pend = 1'b0;
      end
      if (m_valid) begin
        if (lat_arm && !prev_valid && t_valid < 0) t_valid = cyc;
        if (q.size() == 0) begin
          check("col_valid_with_nothing_expected", 128'(m_valid), 128'(0));
        end else begin
          e = q[0];
          check("col_data", m_data, e.data);
          check("col_x_y_eol_eof", 128'({m_x, m_y, m_eol, m_eof}),
                128'({4'(e.x), 4'(e.y), e.eol, e.eof}));
          if (basic_chk && e.x == 0 && e.y == 0)
            check("taps_0_0", m_data, {32'h20, 32'h10, 32'h00, 32'h00});
          if (basic_chk && e.x == 3 && e.y == 2)
            check("taps_3_2", m_data, {32'h33, 32'h33, 32'h23, 32'h13});
          if (basic_chk && e.x == 3 && e.y == 3)
            check("taps_3_3", m_data, {32'h33, 32'h33, 32'h33, 32'h23});
          if (col_ready) begin
            if (e.eof) begin
              check("rready_low_at_eof", 128'(m_rready), 128'(0));
              eof_pend = 1'b1;
            end
            void'(q.pop_front());
          end
        end
      end
      prev_valid = m_valid;
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst_n       = 1'b0;
    rvalid      = 1'b0;
    rdata       = '0;
    use_b       = 1'b0;
    ready_mode  = 1;
    cur_w       = AW;
    cur_h       = AH;
    first_block = -1;
    t_valid     = -1;
    t_hs        = -1;
    acc_cnt     = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_col_valid", 128'(m_valid), 128'(0));
    check("reset_col_data", m_data, 128'(0));
    check("reset_col_x", 128'(m_x), 128'(0));
    check("reset_col_y", 128'(m_y), 128'(0));
    check("reset_eol_eof", 128'({m_eol, m_eof}), 128'(0));
    check("reset_rready", 128'(m_rready), 128'(1));

    // Basic 4x4 frame, pixel = 16y+x, continuous flow.
    basic_chk = 1'b1;
    lat_arm   = 1'b1;
    load_frame(1'b0);
    drive_frame(100, AW * AH);
    wait_empty(200);
    check("first_col_latency", 128'(t_valid - t_hs), 128'(2));
    basic_chk = 1'b0;
    lat_arm   = 1'b0;

    // Downstream stalled: one column moves into the output register, which frees
    // row 0 col 0, so input stops after 3 rows plus that single pixel.
    ready_mode = 0;
    repeat (2) @(posedge clk);
    load_frame(1'b1);
    acc_cnt     = 0;
    first_block = -1;
    fork
      drive_frame(100, AW * AH);
      begin
        int n = 0;
        while (first_block < 0 && n < 500) begin
          @(negedge clk);
          n++;
        end
        check("rready_drop_count", 128'(first_block), 128'(3 * AW + 1));
        repeat (20) @(negedge clk);
        check("accept_count_held", 128'(acc_cnt), 128'(3 * AW + 1));
        check("rready_held_low", 128'(m_rready), 128'(0));
        ready_mode = 1;
      end
    join
    wait_empty(500);

    // Switch to the 8x6 instance: random stalls over three back-to-back frames.
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    use_b = 1'b1;
    cur_w = BW;
    cur_h = BH;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("b_reset_rready", 128'(m_rready), 128'(1));
    check("b_reset_col_valid", 128'(m_valid), 128'(0));
    ready_mode = 2;
    for (int f = 0; f < 3; f++) begin
      load_frame(1'b1);
      drive_frame(50, BW * BH);
    end
    wait_empty(3000);

    // Reset after 10 pixels, then a fresh frame from (0,0).
    load_frame(1'b1);
    drive_frame(50, 10);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset_col_valid", 128'(m_valid), 128'(0));
    check("midreset_col_data", m_data, 128'(0));
    check("midreset_col_x_y", 128'({m_x, m_y}), 128'(0));
    check("midreset_eol_eof", 128'({m_eol, m_eof}), 128'(0));
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("postreset_rready", 128'(m_rready), 128'(1));
    load_frame(1'b1);
    drive_frame(50, BW * BH);
    wait_empty(1000);

    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
